// File: rtl/exp_bit_scanner_if.sv
// ---------------------------------------------------------------------------
// exp_bit_scanner_if
//
// Bundles the start/operand inputs and the bit stream handshake of the
// exponent bit scanner. clk and rst stay plain ports on the module.
//
// Signals:
//   md_start   start pulse (sampled by the scanner only while idle)
//   exp_in     operand to scan, captured with md_start
//   len_in     MSB index of exp_in; all-ones marks a zero operand
//   bit_out    current operand bit
//   bit_idx    index of the bit on bit_out
//   bit_last   bit_idx == 0 while bit_valid
//   bit_valid  bit_out is valid
//   bit_ready  consumer accepts bit_out when bit_valid && bit_ready
//   busy       scanner is streaming or finishing a run
//   md_end     single-cycle completion pulse
//
// Modports:
//   master  the sequencer side: drives start/operand and bit_ready
//   slave   the scanner itself
// ---------------------------------------------------------------------------
interface exp_bit_scanner_if #(
   parameter int WIDTH = 64,
   parameter int LEN_W = 8
) ();

   logic             md_start;
   logic [WIDTH-1:0] exp_in;
   logic [LEN_W-1:0] len_in;
   logic             bit_out;
   logic [LEN_W-1:0] bit_idx;
   logic             bit_last;
   logic             bit_valid;
   logic             bit_ready;
   logic             busy;
   logic             md_end;

   modport master (
      output md_start,
      output exp_in,
      output len_in,
      output bit_ready,
      input  bit_out,
      input  bit_idx,
      input  bit_last,
      input  bit_valid,
      input  busy,
      input  md_end
   );

   modport slave (
      input  md_start,
      input  exp_in,
      input  len_in,
      input  bit_ready,
      output bit_out,
      output bit_idx,
      output bit_last,
      output bit_valid,
      output busy,
      output md_end
   );

endinterface : exp_bit_scanner_if

// File: rtl/exp_bit_scanner.sv
// ---------------------------------------------------------------------------
// exp_bit_scanner
//
// Captures a WIDTH-bit exponent on md_start and streams its bits, one per
// valid/ready handshake, from the MSB index down to bit 0. Feeds the
// square-and-multiply sequencer. A length of all-ones (zero operand) runs
// straight to completion without presenting any bit. Lengths at or beyond
// WIDTH are clamped to WIDTH-1.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   exp_bit_scanner_if.slave (start, operand, bit stream, status)
//
// Parameters:
//   WIDTH  operand width in bits
//   LEN_W  width of the length/index field; 2**LEN_W must exceed WIDTH so
//          that the all-ones code never collides with a real bit index
//
// All outputs come straight from flops, so there is no combinational path
// from bit_ready to bit_valid or bit_out.
// ---------------------------------------------------------------------------
module exp_bit_scanner #(
   parameter int WIDTH = 64,
   parameter int LEN_W = 8
) (
   input logic              clk,
   input logic              rst,
   exp_bit_scanner_if.slave bus
);

   // Bits needed to address one operand bit; idx is clamped below WIDTH so
   // the low IDX_W bits of the index are always a legal bit select.
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [LEN_W-1:0] LEN_WIDTH = LEN_W'(WIDTH);
   localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] operand_q,   operand_d;
   logic [LEN_W-1:0] idx_q,       idx_d;
   logic             bit_out_q,   bit_out_d;
   logic             bit_last_q,  bit_last_d;
   logic             bit_valid_q, bit_valid_d;
   logic             busy_q,      busy_d;
   logic             md_end_q,    md_end_d;

   logic             len_zero;
   logic [LEN_W-1:0] start_idx;
   logic             handshake;

   // All-ones length is the bit-length block's code for a zero operand.
   assign len_zero  = &bus.len_in;

   // Out-of-range (but not all-ones) lengths clamp to the top operand bit.
   assign start_idx = (bus.len_in >= LEN_WIDTH) ? LEN_MAX : bus.len_in;

   assign handshake = bit_valid_q & bus.bit_ready;

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so that no path
      // leaves it unassigned; an unassigned path would infer a latch.
      state_d   = state_q;
      operand_d = operand_q;
      idx_d     = idx_q;

      unique case (state_q)
         IDLE: begin
            if (bus.md_start) begin
               operand_d = bus.exp_in;
               if (len_zero) begin
                  // Nothing to stream: finish immediately.
                  idx_d   = '0;
                  state_d = DONE;
               end else begin
                  idx_d   = start_idx;
                  state_d = SEND;
               end
            end
         end

         SEND: begin
            // md_start is not looked at here, so a start while busy cannot
            // disturb the operand or index of the run in flight.
            if (handshake) begin
               if (idx_q == '0) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end

         DONE: begin
            // A start coinciding with md_end is dropped; only IDLE accepts.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state and registered, so they
      // line up with the state they describe.
      bit_valid_d = (state_d == SEND);
      bit_out_d   = bit_valid_d & operand_d[idx_d[IDX_W-1:0]];
      bit_last_d  = bit_valid_d & (idx_d == '0);
      busy_d      = (state_d != IDLE);
      md_end_d    = (state_d == DONE);
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge, independent of order.
      if (rst) begin
         state_q     <= IDLE;
         operand_q   <= '0;
         idx_q       <= '0;
         bit_out_q   <= 1'b0;
         bit_last_q  <= 1'b0;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         md_end_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         operand_q   <= operand_d;
         idx_q       <= idx_d;
         bit_out_q   <= bit_out_d;
         bit_last_q  <= bit_last_d;
         bit_valid_q <= bit_valid_d;
         busy_q      <= busy_d;
         md_end_q    <= md_end_d;
      end
   end

   assign bus.bit_out   = bit_out_q;
   assign bus.bit_idx   = idx_q;
   assign bus.bit_last  = bit_last_q;
   assign bus.bit_valid = bit_valid_q;
   assign bus.busy      = busy_q;
   assign bus.md_end    = md_end_q;

endmodule : exp_bit_scanner

// File: tb/tb_exp_bit_scanner.sv
// ---------------------------------------------------------------------------
// tb_exp_bit_scanner
//
// Directed self-checking bench for exp_bit_scanner. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_exp_bit_scanner;

   localparam int WIDTH = 64;
   localparam int LEN_W = 8;

   logic clk;
   logic rst;

   int errors = 0;
   int checks = 0;

   exp_bit_scanner_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

   exp_bit_scanner #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a start pulse for one cycle; returns in cycle N+1.
   task automatic start_run(input logic [WIDTH-1:0] e, input logic [LEN_W-1:0] l);
      bus.exp_in   = e;
      bus.len_in   = l;
      bus.md_start = 1'b1;
      tick();
      bus.md_start = 1'b0;
      // Changing the operand after capture must not affect the run.
      bus.exp_in   = ~e;
      bus.len_in   = 8'h05;
   endtask

   // {busy, bit_valid, bit_idx, bit_out, bit_last, md_end}
   function automatic logic [12:0] stream_word(input int idx, input logic b);
      return {1'b1, 1'b1, 8'(idx), b, (idx == 0), 1'b0};
   endfunction

   task automatic test_reset();
      rst          = 1'b1;
      bus.md_start = 1'b1;
      bus.exp_in   = 64'h0D;
      bus.len_in   = 8'd3;
      bus.bit_ready = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.bit_out, bus.bit_idx, bus.bit_last, bus.bit_valid, bus.busy, bus.md_end} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got out=%b idx=%0d last=%b valid=%b busy=%b end=%b, want all 0",
                  bus.bit_out, bus.bit_idx, bus.bit_last, bus.bit_valid, bus.busy, bus.md_end);
      end
      rst          = 1'b0;
      bus.md_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({bus.bit_valid, bus.busy, bus.md_end} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle cycle %0d: got valid=%b busy=%b end=%b, want 000",
                     c, bus.bit_valid, bus.busy, bus.md_end);
         end
      end
   endtask

   task automatic test_basic_stream();
      logic [WIDTH-1:0] e;
      e = 64'h0D;
      bus.bit_ready = 1'b1;
      start_run(e, 8'd3);
      for (int i = 3; i >= 0; i--) begin
         checks++;
         if ({bus.busy, bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last, bus.md_end} !== stream_word(i, e[i])) begin
            errors++;
            $display("FAIL basic_bit idx %0d: got valid=%b idx=%0d out=%b last=%b end=%b, want valid=1 idx=%0d out=%b last=%b end=0",
                     i, bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last, bus.md_end, i, e[i], i == 0);
         end
         tick();
      end
      checks++;
      if ({bus.md_end, bus.busy, bus.bit_valid} !== 3'b110) begin
         errors++;
         $display("FAIL basic_md_end: got end=%b busy=%b valid=%b, want 1 1 0", bus.md_end, bus.busy, bus.bit_valid);
      end
      tick();
      checks++;
      if ({bus.md_end, bus.busy, bus.bit_valid} !== 3'b000) begin
         errors++;
         $display("FAIL basic_idle: got end=%b busy=%b valid=%b, want 0 0 0", bus.md_end, bus.busy, bus.bit_valid);
      end
   endtask

   task automatic test_stall();
      logic [WIDTH-1:0] e;
      int idx_e;
      int cyc;
      e     = 64'h0D;
      idx_e = 3;
      cyc   = 0;
      bus.bit_ready = 1'b0;
      start_run(e, 8'd3);
      while (idx_e >= 0 && cyc < 32) begin
         bus.bit_ready = cyc[0];
         checks++;
         if ({bus.busy, bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last, bus.md_end} !== stream_word(idx_e, e[idx_e])) begin
            errors++;
            $display("FAIL stall_bit cycle %0d: got valid=%b idx=%0d out=%b last=%b end=%b, want valid=1 idx=%0d out=%b last=%b end=0",
                     cyc, bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last, bus.md_end, idx_e, e[idx_e], idx_e == 0);
         end
         tick();
         if (bus.bit_ready) idx_e--;
         cyc++;
      end
      checks++;
      if (idx_e >= 0) begin
         errors++;
         $display("FAIL stall_timeout: got %0d bits left after %0d cycles, want 0", idx_e + 1, cyc);
      end
      checks++;
      if ({bus.md_end, bus.bit_valid} !== 2'b10) begin
         errors++;
         $display("FAIL stall_md_end: got end=%b valid=%b, want 1 0", bus.md_end, bus.bit_valid);
      end
      bus.bit_ready = 1'b1;
      tick();
   endtask

   task automatic test_zero_len_and_clamp();
      logic [WIDTH-1:0] e;
      bus.bit_ready = 1'b1;
      start_run(64'h0, 8'hFF);
      checks++;
      if ({bus.md_end, bus.busy, bus.bit_valid} !== 3'b110) begin
         errors++;
         $display("FAIL zero_len_md_end: got end=%b busy=%b valid=%b, want 1 1 0", bus.md_end, bus.busy, bus.bit_valid);
      end
      tick();
      checks++;
      if ({bus.md_end, bus.busy, bus.bit_valid} !== 3'b000) begin
         errors++;
         $display("FAIL zero_len_idle: got end=%b busy=%b valid=%b, want 0 0 0", bus.md_end, bus.busy, bus.bit_valid);
      end

      e = 64'h8000_0000_0000_0001;
      start_run(e, 8'hC8);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         checks++;
         if ({bus.busy, bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last, bus.md_end} !== stream_word(i, e[i])) begin
            errors++;
            $display("FAIL clamp_bit idx %0d: got valid=%b idx=%0d out=%b last=%b, want valid=1 idx=%0d out=%b last=%b",
                     i, bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last, i, e[i], i == 0);
         end
         tick();
      end
      checks++;
      if ({bus.md_end, bus.bit_valid} !== 2'b10) begin
         errors++;
         $display("FAIL clamp_md_end: got end=%b valid=%b, want 1 0", bus.md_end, bus.bit_valid);
      end
      tick();
   endtask

   task automatic test_ignore_midrun_and_reset();
      logic [WIDTH-1:0] e;
      e = 64'h0D;
      bus.bit_ready = 1'b1;
      start_run(e, 8'd3);
      checks++;
      if ({bus.bit_valid, bus.bit_idx, bus.bit_out} !== {1'b1, 8'd3, 1'b1}) begin
         errors++;
         $display("FAIL midrun_bit3: got valid=%b idx=%0d out=%b, want 1 3 1", bus.bit_valid, bus.bit_idx, bus.bit_out);
      end
      tick();
      checks++;
      if ({bus.bit_valid, bus.bit_idx, bus.bit_out} !== {1'b1, 8'd2, 1'b1}) begin
         errors++;
         $display("FAIL midrun_bit2: got valid=%b idx=%0d out=%b, want 1 2 1", bus.bit_valid, bus.bit_idx, bus.bit_out);
      end
      // Start while busy: must be ignored.
      bus.md_start = 1'b1;
      bus.exp_in   = 64'hFF;
      bus.len_in   = 8'd7;
      tick();
      bus.md_start = 1'b0;
      checks++;
      if ({bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last} !== {1'b1, 8'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midrun_bit1: got valid=%b idx=%0d out=%b last=%b, want 1 1 0 0",
                  bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last);
      end
      tick();
      checks++;
      if ({bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last} !== {1'b1, 8'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL midrun_bit0: got valid=%b idx=%0d out=%b last=%b, want 1 0 1 1",
                  bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last);
      end
      // Abort before the last bit is accepted.
      bus.bit_ready = 1'b0;
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.bit_out, bus.bit_idx, bus.bit_last, bus.bit_valid, bus.busy, bus.md_end} !== 13'd0) begin
         errors++;
         $display("FAIL abort_outputs: got out=%b idx=%0d last=%b valid=%b busy=%b end=%b, want all 0",
                  bus.bit_out, bus.bit_idx, bus.bit_last, bus.bit_valid, bus.busy, bus.md_end);
      end
      rst = 1'b0;
      bus.bit_ready = 1'b1;
      tick();
      checks++;
      if ({bus.md_end, bus.busy, bus.bit_valid} !== 3'b000) begin
         errors++;
         $display("FAIL abort_no_md_end: got end=%b busy=%b valid=%b, want 0 0 0", bus.md_end, bus.busy, bus.bit_valid);
      end
   endtask

   task automatic test_done_start();
      logic [WIDTH-1:0] e;
      e = 64'h0D;
      bus.bit_ready = 1'b1;
      start_run(64'h0, 8'hFF);
      checks++;
      if ({bus.md_end, bus.busy, bus.bit_valid} !== 3'b110) begin
         errors++;
         $display("FAIL done_md_end: got end=%b busy=%b valid=%b, want 1 1 0", bus.md_end, bus.busy, bus.bit_valid);
      end
      // Start held through the DONE cycle and into the next IDLE cycle.
      bus.md_start = 1'b1;
      bus.exp_in   = e;
      bus.len_in   = 8'd3;
      tick();
      checks++;
      if ({bus.md_end, bus.busy, bus.bit_valid} !== 3'b000) begin
         errors++;
         $display("FAIL done_start_ignored: got end=%b busy=%b valid=%b, want 0 0 0", bus.md_end, bus.busy, bus.bit_valid);
      end
      tick();
      bus.md_start = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         checks++;
         if ({bus.busy, bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last, bus.md_end} !== stream_word(i, e[i])) begin
            errors++;
            $display("FAIL restart_bit idx %0d: got valid=%b idx=%0d out=%b last=%b, want valid=1 idx=%0d out=%b last=%b",
                     i, bus.bit_valid, bus.bit_idx, bus.bit_out, bus.bit_last, i, e[i], i == 0);
         end
         tick();
      end
      checks++;
      if ({bus.md_end, bus.bit_valid} !== 2'b10) begin
         errors++;
         $display("FAIL restart_md_end: got end=%b valid=%b, want 1 0", bus.md_end, bus.bit_valid);
      end
      tick();
   endtask

   initial begin
      rst           = 1'b1;
      bus.md_start  = 1'b0;
      bus.exp_in    = '0;
      bus.len_in    = '0;
      bus.bit_ready = 1'b0;

      test_reset();
      test_basic_stream();
      test_stall();
      test_zero_len_and_clamp();
      test_ignore_midrun_and_reset();
      test_done_start();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_exp_bit_scanner
